key_press_conditioner: RTL

- Front end of the lock's key interface. Takes raw, bouncing, active-low DE1-SoC push buttons and turns them into clean one-hot key events for the digital lock FSM's `key[3:0]` input.
- Each physical press produces exactly one single-cycle pulse on the key that was pressed.
- Further pulses are blocked until every key has been released.
- Also reports debounced key levels and a multi-key (chord) indication.

---
 rtl/key_press_conditioner.sv | 105 ++++++++++
 1 files changed

// File: rtl/key_press_conditioner.sv
// Push-button front end: synchronizes and debounces active-low keys, then emits
// one single-cycle one-hot pulse per press, re-arming only after all keys are released.
module key_press_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic                enable,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                multi,
  output logic                armed
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_ARMED, ST_HELD} state_t;

  logic [NUM_KEYS-1:0] sync_p0;
  logic [NUM_KEYS-1:0] sync_p1;
  logic [CNT_W-1:0]    cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] held_p1;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] pulse_next;
  state_t              state;
  state_t              state_next;

  function automatic logic [NUM_KEYS-1:0] isolate_lowest(input logic [NUM_KEYS-1:0] v);
    return v & (~v + NUM_KEYS'(1));
  endfunction

  // Stage p0/p1: two-flop synchronizer, inverted so 1 means pressed
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= ~key_n;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: level changes only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_held <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync_p1[i] == key_held[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          key_held[i] <= sync_p1[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge detect on the debounced level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) held_p1 <= '0;
    else       held_p1 <= key_held;
  end

  assign rise  = key_held & ~held_p1;
  assign multi = (key_held & (key_held - NUM_KEYS'(1))) != '0;
  assign armed = (state == ST_ARMED);

  always_comb begin
    state_next = state;
    pulse_next = '0;
    case (state)
      ST_ARMED: begin
        if (enable && (rise != '0)) begin
          pulse_next = isolate_lowest(rise);
          state_next = ST_HELD;
        end else if (!enable && (key_held != '0)) begin
          state_next = ST_HELD;
        end
      end
      ST_HELD: begin
        if (key_held == '0) state_next = ST_ARMED;
      end
      default: state_next = ST_ARMED;
    endcase
  end

  // Press FSM and registered pulse output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_ARMED;
      key_pulse <= '0;
    end else begin
      state     <= state_next;
      key_pulse <= pulse_next;
    end
  end

endmodule
